// File: rtl/mul_seq.sv
// Sequential radix-2^DIGIT multiplier: one DIGIT-bit slice of the multiplier per
// RUN cycle, sign applied to the magnitude product in a final FIX cycle.
module mul_seq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   ain,
  input  logic [WIDTH-1:0]   bin,
  output logic [2*WIDTH-1:0] yout,
  output logic               busy,
  output logic               done
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_nxt;
  logic [W2-1:0]    mc;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] mag_b;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             last;

  // Two's-complement negation of the most negative value wraps to 2^(WIDTH-1),
  // which is exactly its magnitude when read as unsigned.
  always_comb begin
    abs_a = (sgn && ain[WIDTH-1]) ? -ain : ain;
    abs_b = (sgn && bin[WIDTH-1]) ? -bin : bin;
    last  = (cnt == CW'(N - 1));
    busy  = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The counter*DIGIT shift is realised by shifting the multiplicand left and
  // the multiplier right by DIGIT each RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mc    <= '0;
      acc   <= '0;
      mag_b <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      yout  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mc    <= {{WIDTH{1'b0}}, abs_a};
            mag_b <= abs_b;
            neg   <= sgn & (ain[WIDTH-1] ^ bin[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= acc + mc * W2'(mag_b[DIGIT-1:0]);
          mc    <= mc << DIGIT;
          mag_b <= mag_b >> DIGIT;
          cnt   <= cnt + CW'(1);
        end
        FIX: begin
          yout <= neg ? -acc : acc;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
